// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one toggle flip-flop bank between NREQ requesters.
// Optional TFF_TOGGLE_COUNT_EN adds a saturating popcount of applied toggles.
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
`ifdef TFF_TOGGLE_COUNT_EN
  ,
  output logic [15:0]           tog_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [IW-1:0]    pick;
  logic             found;
  logic [WIDTH-1:0] cap;

  // first requester at or after ptr, wrapping
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      win   <= '0;
      cap   <= '0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            win   <= pick;
            gnt   <= NREQ'(1) << pick;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req[win]) begin
            cap   <= mask[int'(win)*WIDTH +: WIDTH];
            state <= S_APPLY;
          end else begin
            gnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_APPLY: begin
          done  <= gnt;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= '0;
          gnt   <= '0;
          ptr   <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // clr wins over a toggle landing on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (state == S_APPLY) begin
      q <= q ^ cap;
    end
  end

`ifdef TFF_TOGGLE_COUNT_EN
  logic [5:0]  pc;
  logic [16:0] sum;

  always_comb begin
    pc = '0;
    for (int b = 0; b < WIDTH; b++) begin
      pc = pc + 6'(cap[b]);
    end
    sum = {1'b0, tog_cnt} + 17'(pc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_cnt <= '0;
    end else if (state == S_APPLY) begin
      tog_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
`endif

endmodule
